vector_lane_streamer: RTL and testbench
=======================================

# vector_lane_streamer

Sequential, parametrised successor to the energy monitor's single-bit vector mux. It captures one DATAWIDTH-bit vector (e.g. a spin state) per input handshake. It then streams that vector out LANES bits per beat, in chunk order, over a valid/ready interface, with the chunk index and a last flag. It sits between the spin-state register and the energy monitor's per-chunk accumulation datapath, replacing per-bit index muxing driven by an external counter.

## Interface
- DATAWIDTH, 256, width of the captured vector.
- LANES, 4, bits emitted per beat; must be a power of two and divide DATAWIDTH.
- NCHUNK, DATAWIDTH/LANES, beats per vector (derived, not overridden).
- IDX_BIT, max(1, $clog2(NCHUNK)), width of idx_o (derived).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- en_i  input  1  enable for accepting new vectors; does not pause a stream in progress.
- in_valid_i  input  1  data_i is valid.
- in_ready_o  output  1  block accepts data_i this cycle.
- data_i  input  DATAWIDTH  vector to stream.
- out_valid_o  output  1  data_o/idx_o/last_o are valid.
- out_ready_i  input  1  consumer takes the beat this cycle.
- data_o  output  LANES  current chunk, bit j = vector bit idx_o*LANES+j; all zeros when out_valid_o is 0.
- idx_o  output  IDX_BIT  chunk index of current beat; 0 when out_valid_o is 0.
- last_o  output  1  current beat is the final chunk of the vector.
- busy_o  output  1  high in STREAM state.

## Operation
- Two-state FSM: IDLE, STREAM. Internal state: vector register (DATAWIDTH), chunk counter (IDX_BIT).
- in_ready_o = en_i & !rst_i & (IDLE | (STREAM & out_valid_o & out_ready_i & last_o)). The path is combinational from out_ready_i and en_i.
- Accept (in_valid_i & in_ready_o):
  - latch data_i;
  - set counter to first index (0, or NCHUNK-1 with the macro);
  - next state STREAM.
- STREAM:
  - out_valid_o = 1; data_o = vector_reg[counter*LANES +: LANES]; idx_o = counter.
  - last_o = 1 when counter equals the final index.
  - Beat transfer on out_valid_o & out_ready_i:
    - not last: counter steps by ±1 and state stays STREAM;
    - last and a simultaneous accept: reload the vector and counter, stay STREAM;
    - last and no accept: go to IDLE.
- No beat while out_ready_i is low: all outputs hold stable (the valid/ready stability rule).
- en_i low in STREAM: the stream completes normally; only a new capture is blocked.
- NCHUNK = 1: every beat has last_o = 1, idx_o = 0, and one beat is sent per vector.
- in_valid_i is ignored while in_ready_o is 0; the upstream must hold data until the handshake.

## Timing
- Reset values: state IDLE, counter 0, vector register 0, out_valid_o 0, data_o 0, idx_o 0, last_o 0, busy_o 0, in_ready_o 0.
- Latency: a vector accepted at edge k presents its first beat in the cycle after edge k, from registered state.
- Throughput: NCHUNK beats per vector. With out_ready_i held high and in_valid_i held high, back-to-back vectors run with zero bubble cycles.
- Reset mid-stream: the vector is discarded and all outputs take their reset values from the next cycle. in_ready_o is low in every cycle where rst_i is high.

## Configuration
- VECTOR_LANE_STREAMER_MSB_FIRST_EN:
  - defined: stream starts at chunk NCHUNK-1 and decrements; last_o is asserted at idx_o = 0;
  - undefined (default): stream starts at chunk 0 and increments; last_o is asserted at idx_o = NCHUNK-1.

## Test plan
All scenarios use DATAWIDTH=16, LANES=4.
- Basic stream: accept 0xA5C3 with out_ready_i=1 -> beats data_o 0x3, 0xC, 0x5, 0xA with idx_o 0..3 on consecutive cycles; last_o only on idx 3; then IDLE.
- Back-pressure: same vector, out_ready_i low for 3 cycles on idx 1 -> data_o=0xC and idx_o=1 held stable; sequence resumes intact.
- Back-to-back: vectors 0x1234 then 0xFEDC, in_valid_i and out_ready_i always high -> 8 consecutive beats 4,3,2,1,C,D,E,F; second accept coincides with the last beat of the first vector.
- Enable gating: en_i=0 with in_valid_i=1 -> in_ready_o=0 and no capture. Drop en_i mid-stream -> the current vector still completes all 4 beats.
- Reset mid-stream: rst_i high after beat idx 1 -> next cycle out_valid_o=0, data_o=0, busy_o=0. A fresh vector then streams from idx 0.
- MSB-first build with the macro defined: 0xA5C3 -> beats 0xA, 0x5, 0xC, 0x3 with idx_o 3..0; last_o on idx 0.

Source files
------------

// File: rtl/vector_lane_streamer.sv
// vector_lane_streamer
// Captures one DATAWIDTH-bit vector per input handshake and streams it out
// LANES bits per beat over a valid/ready interface, with the chunk index and a
// last-beat flag. All stream outputs come from registers. in_ready_o is the
// only combinational output: it lets a new vector load on the same edge as the
// final beat of the previous one, so back-to-back vectors need no bubble.
//
// Build option:
//   VECTOR_LANE_STREAMER_MSB_FIRST_EN - when defined, the stream starts at
//   chunk NCHUNK-1 and counts down, and last_o is raised at index 0. When it
//   is undefined (the default), the stream starts at chunk 0 and counts up,
//   and last_o is raised at index NCHUNK-1.
module vector_lane_streamer #(
  parameter int DATAWIDTH = 256,
  parameter int LANES     = 4,
  localparam int NCHUNK   = DATAWIDTH / LANES,
  localparam int IDX_BIT  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATAWIDTH-1:0] data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LANES-1:0]     data_o,
  output logic [IDX_BIT-1:0]   idx_o,
  output logic                 last_o,
  output logic                 busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam logic [IDX_BIT-1:0] IDX_ONE = IDX_BIT'(1);
`ifdef VECTOR_LANE_STREAMER_MSB_FIRST_EN
  localparam logic [IDX_BIT-1:0] FIRST_IDX = IDX_BIT'(NCHUNK - 1);
  localparam logic [IDX_BIT-1:0] LAST_IDX  = IDX_BIT'(0);
`else
  localparam logic [IDX_BIT-1:0] FIRST_IDX = IDX_BIT'(0);
  localparam logic [IDX_BIT-1:0] LAST_IDX  = IDX_BIT'(NCHUNK - 1);
`endif

  state_t                        state_r;
  logic [NCHUNK-1:0][LANES-1:0]  vec_r;
  logic [NCHUNK-1:0][LANES-1:0]  data_chunks_s;
  logic [IDX_BIT-1:0]            cnt_r;
  logic [IDX_BIT-1:0]            cnt_next_s;
  logic [LANES-1:0]              data_r;
  logic                          valid_r;
  logic                          last_r;
  logic                          busy_r;
  logic                          beat_s;
  logic                          in_ready_s;
  logic                          accept_s;

  // The packed 2-D view lets a chunk be selected by its index alone.
  assign data_chunks_s = data_i;

`ifdef VECTOR_LANE_STREAMER_MSB_FIRST_EN
  assign cnt_next_s = cnt_r - IDX_ONE;
`else
  assign cnt_next_s = cnt_r + IDX_ONE;
`endif

  assign beat_s     = valid_r & out_ready_i;
  assign in_ready_s = en_i & ~rst_i &
                      ((state_r == ST_IDLE) |
                       ((state_r == ST_STREAM) & beat_s & last_r));
  assign accept_s   = in_valid_i & in_ready_s;

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = valid_r;
  assign data_o      = data_r;
  assign idx_o       = cnt_r;
  assign last_o      = last_r;
  assign busy_o      = busy_r;

  // FSM: load on accept, step the chunk counter on each non-final beat,
  // drop to IDLE after the final beat, and hold everything while stalled.
  // Outputs are loaded with the values for the next beat, so they are ready
  // one cycle after the edge that caused the change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      vec_r   <= '0;
      cnt_r   <= IDX_BIT'(0);
      data_r  <= LANES'(0);
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else if (accept_s) begin
      // Entered from IDLE, or on the final beat of the previous vector.
      state_r <= ST_STREAM;
      vec_r   <= data_chunks_s;
      cnt_r   <= FIRST_IDX;
      data_r  <= data_chunks_s[FIRST_IDX];
      valid_r <= 1'b1;
      last_r  <= (FIRST_IDX == LAST_IDX);
      busy_r  <= 1'b1;
    end else if (beat_s && !last_r) begin
      state_r <= ST_STREAM;
      cnt_r   <= cnt_next_s;
      data_r  <= vec_r[cnt_next_s];
      valid_r <= 1'b1;
      last_r  <= (cnt_next_s == LAST_IDX);
      busy_r  <= 1'b1;
    end else if (beat_s) begin
      // The final beat was taken and no new vector is arriving.
      state_r <= ST_IDLE;
      cnt_r   <= IDX_BIT'(0);
      data_r  <= LANES'(0);
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      // Idle, or stalled with out_ready_i low: every output holds its value.
      state_r <= state_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: tb/tb_vector_lane_streamer.sv
// Self-checking bench for vector_lane_streamer (DATAWIDTH=16, LANES=4).
// A vector-level reference model (current vector + beats already sent)
// predicts every output on each falling edge. Directed scenarios add literal
// expectations, followed by a randomized phase.
module tb_vector_lane_streamer;

  localparam int DW  = 16;
  localparam int LN  = 4;
  localparam int NCH = DW / LN;
`ifdef VECTOR_LANE_STREAMER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] data = 16'h0000;
  logic          in_ready;
  logic          out_valid;
  logic [LN-1:0] data_o;
  logic [1:0]    idx_o;
  logic          last_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model: whether a vector is active, the vector itself, and how
  // many of its beats have already been sent.
  bit            m_act = 1'b0;
  int            m_pos = 0;
  logic [DW-1:0] m_vec = 16'h0000;

  vector_lane_streamer #(.DATAWIDTH(DW), .LANES(LN)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .data_i(data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .data_o(data_o), .idx_o(idx_o),
    .last_o(last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the rising edge, using the inputs held across the edge.
  always @(posedge clk) begin
    bit rdy;
    bit beat;
    if (rst) begin
      m_act = 1'b0;
      m_pos = 0;
      m_vec = 16'h0000;
    end else begin
      rdy  = en && (!m_act || (out_ready && m_pos == NCH - 1));
      beat = m_act && out_ready;
      if (beat) begin
        if (m_pos == NCH - 1) m_act = 1'b0;
        else m_pos = m_pos + 1;
      end
      if (in_valid && rdy) begin
        m_act = 1'b1;
        m_vec = data;
        m_pos = 0;
      end
    end
  end

  // Compare process: check every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    int         ch;
    logic [3:0] ed;
    bit         erdy;
    if (chk_on) begin
      ch   = MSB ? (NCH - 1 - m_pos) : m_pos;
      ed   = m_act ? 4'((m_vec >> (ch * LN)) & 16'h000F) : 4'h0;
      erdy = en && !rst && (!m_act || (out_ready && m_pos == NCH - 1));
      chk("model_out_valid", 32'(out_valid), 32'(m_act));
      chk("model_data",      32'(data_o),    32'(ed));
      chk("model_idx",       32'(idx_o),     m_act ? 32'(ch) : 32'd0);
      chk("model_last",      32'(last_o),    32'(m_act && m_pos == NCH - 1));
      chk("model_busy",      32'(busy_o),    32'(m_act));
      chk("model_in_ready",  32'(in_ready),  32'(erdy));
    end
  end

  function automatic int exp_idx(input int k);
    return MSB ? (NCH - 1 - k) : k;
  endfunction

  initial begin
    logic [3:0] basic_exp [4];
    logic [3:0] b2b_exp [8];
    logic [3:0] fresh_data;
    int         beats;
    if (MSB) begin
      basic_exp  = '{4'hA, 4'h5, 4'hC, 4'h3};
      b2b_exp    = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'hE, 4'hD, 4'hC};
      fresh_data = 4'h0;
    end else begin
      basic_exp  = '{4'h3, 4'hC, 4'h5, 4'hA};
      b2b_exp    = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hC, 4'hD, 4'hE, 4'hF};
      fresh_data = 4'h3;
    end

    // Reset state.
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data",      32'(data_o),    32'd0);
    chk("rst_idx",       32'(idx_o),     32'd0);
    chk("rst_last",      32'(last_o),    32'd0);
    chk("rst_busy",      32'(busy_o),    32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic stream.
    en = 1'b1; in_valid = 1'b1; data = 16'hA5C3; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("basic_data", 32'(data_o), 32'(basic_exp[k]));
      chk("basic_idx",  32'(idx_o),  32'(exp_idx(k)));
      chk("basic_last", 32'(last_o), 32'(k == 3));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("basic_idle", 32'(out_valid), 32'd0);

    // Back-pressure on the second beat.
    @(posedge clk); #1;
    in_valid = 1'b1; data = 16'hA5C3; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(data_o), 32'(basic_exp[1]));
      chk("bp_hold_idx",  32'(idx_o),  32'(exp_idx(1)));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("bp_resume_data", 32'(data_o), 32'(basic_exp[k]));
      @(posedge clk); #1;
    end

    // Back-to-back vectors with no bubble.
    in_valid = 1'b1; data = 16'h1234;
    @(posedge clk); #1;
    data = 16'hFEDC;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_data",  32'(data_o),    32'(b2b_exp[k]));
      chk("b2b_valid", 32'(out_valid), 32'd1);
      if (k == 3) chk("b2b_ready_on_last", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (k == 3) in_valid = 1'b0;
    end

    // Enable gating.
    en = 1'b0; in_valid = 1'b1; data = 16'h5A5A;
    @(negedge clk);
    chk("en_gate_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("en_gate_nocap", 32'(out_valid), 32'd0);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; data = 16'h0F0F;
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) beats++;
      @(posedge clk); #1;
    end
    chk("en_drop_beats", 32'(beats), 32'd4);
    in_valid = 1'b0; en = 1'b1;

    // Reset mid-stream.
    in_valid = 1'b1; data = 16'hA5C3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; data = 16'hFFFF;
    @(negedge clk);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data",  32'(data_o),    32'd0);
    chk("rst_mid_busy",  32'(busy_o),    32'd0);
    in_valid = 1'b1; data = 16'h0123;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fresh_idx",  32'(idx_o),  32'(exp_idx(0)));
    chk("fresh_data", 32'(data_o), 32'(fresh_data));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
    end

    // Randomized phase, checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(63) == 0);
      en        = ($urandom_range(3) != 0);
      in_valid  = $urandom_range(1);
      out_ready = ($urandom_range(9) < 7);
      data      = 16'($urandom);
      @(posedge clk); #1;
    end

    rst = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
    end
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
